pipe_stall_ctrl: RTL and testbench

Pipeline stall/flush controller for the 5-stage RISC-V core. It consumes the hazard requests:
- load-use match between IF/ID and ID/EX,
- branch-taken redirect from EX,
- multi-cycle data-memory busy.

From these it drives the write-enables, flushes and bubble-injects of the PC and the pipeline registers. It owns a small FSM for multi-cycle memory waits, a timeout watchdog, and saturating stall/flush performance counters.

---
 rtl/pipe_stall_ctrl_pkg.sv | 6 +
 rtl/pipe_stall_ctrl_if.sv | 33 +++
 rtl/pipe_stall_ctrl_sat_counter.sv | 18 +
 rtl/pipe_stall_ctrl.sv | 63 ++++++
 tb/tb_pipe_stall_ctrl.sv | 128 ++++++++++++
 5 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: shared types and constants for the pipeline stall/flush controller
package pipe_stall_ctrl_pkg;
  localparam int REG_W_DEF = 5;
  localparam logic [REG_W_DEF-1:0] ZERO_REG = '0;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2} state_e;
endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: hazard requests in, pipeline enables/flushes and counters out
interface pipe_stall_ctrl_if
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = 32
);
  logic             idex_memRead;
  logic [REG_W-1:0] idex_rd;
  logic [REG_W-1:0] ifid_rs1;
  logic [REG_W-1:0] ifid_rs2;
  logic             ex_branch_taken;
  logic             dmem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_freeze;
  logic             memwb_bubble;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  modport master (
    output idex_memRead, idex_rd, ifid_rs1, ifid_rs2, ex_branch_taken, dmem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, memwb_bubble,
           mem_timeout, stall_count, flush_count
  );
  modport slave (
    input  idex_memRead, idex_rd, ifid_rs1, ifid_rs2, ex_branch_taken, dmem_busy,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, memwb_bubble,
           mem_timeout, stall_count, flush_count
  );
endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// pipe_stall_ctrl_sat_counter: enabled up-counter that sticks at all-ones
module pipe_stall_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // advance only when enabled and not yet saturated
  always_comb cnt_d = (en_i && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush/bubble control with memory-wait FSM, watchdog and perf counters
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int REG_W    = REG_W_DEF,
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 16
) (
  input logic            clk,
  input logic            rst,
  pipe_stall_ctrl_if.slave bus
);
  localparam int WC_W = $clog2(MAX_WAIT) + 1;
  localparam logic [1:0] S_RUN      = RUN;
  localparam logic [1:0] S_MEM_WAIT = MEM_WAIT;
  localparam logic [1:0] S_HALT     = HALT;
  logic [1:0]      state_q, state_d;
  logic [WC_W-1:0] wait_q, wait_d;
  logic            timeout_q, timeout_d;
  logic            lu, halt, busy, br, stall_en, flush_en;
  // hazard decode and the prioritised combinational controls; rst forces the safe pattern
  always_comb begin
    busy = bus.dmem_busy;
    br   = bus.ex_branch_taken;
    halt = state_q == S_HALT;
    lu   = bus.idex_memRead && (bus.idex_rd != REG_W'(ZERO_REG)) &&
           (bus.idex_rd == bus.ifid_rs1 || bus.idex_rd == bus.ifid_rs2);
    bus.pc_write     = !rst && !halt && !busy && (br || !lu);
    bus.ifid_write   = !rst && !halt && !busy && (br || !lu);
    bus.ifid_flush   = rst || (!halt && !busy && br);
    bus.idex_bubble  = rst || (!halt && !busy && (br || lu));
    bus.pipe_freeze  = !rst && (halt || busy);
    bus.memwb_bubble = rst || halt || busy;
    bus.mem_timeout  = timeout_q;
    stall_en = !halt && (busy || (!br && lu));
    flush_en = !halt && !busy && br;
  end
  // memory-wait FSM: a busy streak reaching MAX_WAIT cycles traps in HALT until reset
  always_comb begin
    wait_d    = busy ? wait_q + WC_W'(1) : '0;
    state_d   = halt ? S_HALT :
                !busy ? S_RUN :
                (state_q == S_MEM_WAIT && wait_q == WC_W'(MAX_WAIT - 1)) ? S_HALT : S_MEM_WAIT;
    timeout_d = timeout_q || (state_d == S_HALT);
  end
  // state registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= S_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  pipe_stall_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .en_i(stall_en), .cnt_o(bus.stall_count)
  );
  pipe_stall_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .en_i(flush_en), .cnt_o(bus.flush_count)
  );
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: two configurations driven in lockstep, scoreboarded against a behavioural model
module tb_pipe_stall_ctrl;
  typedef struct {
    logic [6:0] ctl;
    longint     stall;
    longint     flush;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pipe_stall_ctrl_if #(.REG_W(5), .CNT_W(32)) if_a ();
  pipe_stall_ctrl_if #(.REG_W(5), .CNT_W(4))  if_b ();
  pipe_stall_ctrl #(.REG_W(5), .CNT_W(32), .MAX_WAIT(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  pipe_stall_ctrl #(.REG_W(5), .CNT_W(4),  .MAX_WAIT(4)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  exp_t   qa[$], qb[$];
  int     total = 0, bad = 0;
  int     streak[2], halted[2];
  longint sc[2], fc[2];
  int     mw[2]   = '{8, 4};
  longint cmax[2] = '{64'hFFFF_FFFF, 64'd15};
  // ctl order: pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, memwb_bubble, mem_timeout
  function automatic exp_t model(input int id, input logic r, mr, input logic [4:0] rd, rs1, rs2,
                                 input logic br, busy);
    exp_t e;
    logic lu;
    lu = mr && rd != 0 && (rd == rs1 || rd == rs2);
    if (r) begin
      streak[id] = 0; halted[id] = 0; sc[id] = 0; fc[id] = 0;
      e.ctl = 7'b0011010; e.stall = 0; e.flush = 0;
      return e;
    end
    e.stall = sc[id];
    e.flush = fc[id];
    if (halted[id] != 0) begin
      e.ctl = 7'b0000111;
      return e;
    end
    if (busy) begin
      e.ctl = 7'b0000110;
      if (sc[id] < cmax[id]) sc[id]++;
    end else if (br) begin
      e.ctl = 7'b1111000;
      if (fc[id] < cmax[id]) fc[id]++;
    end else if (lu) begin
      e.ctl = 7'b0001000;
      if (sc[id] < cmax[id]) sc[id]++;
    end else begin
      e.ctl = 7'b1100000;
    end
    streak[id] = busy ? streak[id] + 1 : 0;
    if (streak[id] >= mw[id]) halted[id] = 1;
    return e;
  endfunction
  task automatic step(input logic r, mr, input logic [4:0] rd, rs1, rs2, input logic br, busy);
    @(posedge clk);
    #1;
    rst = r;
    if_a.idex_memRead = mr; if_a.idex_rd = rd; if_a.ifid_rs1 = rs1; if_a.ifid_rs2 = rs2;
    if_a.ex_branch_taken = br; if_a.dmem_busy = busy;
    if_b.idex_memRead = mr; if_b.idex_rd = rd; if_b.ifid_rs1 = rs1; if_b.ifid_rs2 = rs2;
    if_b.ex_branch_taken = br; if_b.dmem_busy = busy;
    qa.push_back(model(0, r, mr, rd, rs1, rs2, br, busy));
    qb.push_back(model(1, r, mr, rd, rs1, rs2, br, busy));
  endtask
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask
  // monitor: whenever an expectation is pending, compare against the DUT away from the clock edge
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("ctl_a", {57'b0, if_a.pc_write, if_a.ifid_write, if_a.ifid_flush, if_a.idex_bubble,
                    if_a.pipe_freeze, if_a.memwb_bubble, if_a.mem_timeout}, {57'b0, e.ctl});
      chk("stall_a", {32'b0, if_a.stall_count}, e.stall);
      chk("flush_a", {32'b0, if_a.flush_count}, e.flush);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("ctl_b", {57'b0, if_b.pc_write, if_b.ifid_write, if_b.ifid_flush, if_b.idex_bubble,
                    if_b.pipe_freeze, if_b.memwb_bubble, if_b.mem_timeout}, {57'b0, e.ctl});
      chk("stall_b", {60'b0, if_b.stall_count}, e.stall);
      chk("flush_b", {60'b0, if_b.flush_count}, e.flush);
    end
  end
  initial begin
    if_a.idex_memRead = 0; if_a.idex_rd = 0; if_a.ifid_rs1 = 0; if_a.ifid_rs2 = 0;
    if_a.ex_branch_taken = 0; if_a.dmem_busy = 0;
    if_b.idex_memRead = 0; if_b.idex_rd = 0; if_b.ifid_rs1 = 0; if_b.ifid_rs2 = 0;
    if_b.ex_branch_taken = 0; if_b.dmem_busy = 0;
    repeat (2) step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 5, 0, 0, 0);
    step(0, 0, 0, 5, 0, 0, 0);
    step(0, 1, 0, 3, 0, 0, 0);
    step(0, 0, 7, 7, 7, 0, 0);
    step(0, 1, 9, 1, 9, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 4, 4, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 1, 6, 6, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    repeat (20) step(0, 1, 5, 5, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] rd, rs1, rs2;
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      step($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)), rd, rs1, rs2,
           $urandom_range(0, 4) == 0, $urandom_range(0, 99) < 30);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("drain", 64'(qa.size() + qb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
